dadda_final_adder: RTL

- Carry-propagate stage directly downstream of the Dadda reduction block.
- Consumes the two 16-bit rows (sum row and carry row) that the reduction tree leaves, and adds them serially in CHUNK-bit slices to form the final 16-bit product.
- Handshaked on both sides; one operand pair in flight at a time.
- Carry-out beyond bit 15 is flagged, since a correct 8x8 reduction never produces it.

---
 rtl/dadda_pkg.sv | 20 ++
 rtl/dadda_final_adder_if.sv | 29 ++
 rtl/dadda_final_adder_ripple_slice_adder.sv | 40 ++++
 rtl/dadda_final_adder.sv | 108 ++++++++++
 4 files changed

// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda multiplier final carry-propagate stage.
//   DADDA_W     : width of each reduced row and of the product
//   DADDA_CHUNK : default number of bits added per cycle
//   NSLICE      : slices per operation at the default chunk size
//   IDX_W       : width of a slice index at the default chunk size
//   state_t     : sequencing states of the final adder
package dadda_pkg;

  localparam int DADDA_W     = 16;
  localparam int DADDA_CHUNK = 4;
  localparam int NSLICE      = DADDA_W / DADDA_CHUNK;
  localparam int IDX_W       = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dadda_final_adder_if.sv
// Row-pair input / product output bus of the final adder.
//   in_valid/in_ready   : row pair handshake, in_row0/in_row1 carry the rows
//   out_valid/out_ready : result handshake, out_prod/out_ovf carry the result
// Handshake rule on both sides: a transfer happens on a rising edge where
// valid and ready are both high; valid, once raised, holds its payload stable
// until that transfer.
// master : the producer/consumer environment; slave : the adder itself.
interface dadda_final_adder_if #(
  parameter int WIDTH = dadda_pkg::DADDA_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_row0;
  logic [WIDTH-1:0] in_row1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_prod;
  logic             out_ovf;

  modport master (
    output in_valid, in_row0, in_row1, out_ready,
    input  in_ready, out_valid, out_prod, out_ovf
  );

  modport slave (
    input  in_valid, in_row0, in_row1, out_ready,
    output in_ready, out_valid, out_prod, out_ovf
  );
endinterface

// File: rtl/dadda_final_adder_ripple_slice_adder.sv
// Combinational building blocks of the final adder datapath.
//   full_adder         : one-bit full adder cell (a, b, ci -> s, co)
//   ripple_slice_adder : W-bit ripple chain of full_adder cells
//                        ports a, b, cin -> sum, cout
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_slice_adder #(
  parameter int W = dadda_pkg::DADDA_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  // c[i] is the carry into bit i; c[W] leaves the slice.
  logic [W:0] c;

  assign c[0] = cin;
  assign cout = c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end
endmodule

// File: rtl/dadda_final_adder.sv
// Final carry-propagate adder behind the Dadda reduction tree.
// Adds the two reduced rows CHUNK bits per cycle through one ripple slice.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : row pair in / product out handshake bus (slave side)
//   busy       : high while an operation is in ADD or DONE
//   state_dbg  : current sequencing state
// One operand pair is in flight at a time: in_ready is low in ADD and DONE.
module dadda_final_adder
  import dadda_pkg::*;
#(
  parameter int WIDTH = DADDA_W,
  parameter int CHUNK = DADDA_CHUNK
) (
  input  logic                 clk,
  input  logic                 rst,
  dadda_final_adder_if.slave   bus,
  output logic                 busy,
  output state_t               state_dbg
);

  localparam int NSL = WIDTH / CHUNK;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] row0_q, row1_q, result_q;
  logic             ovf_q;

  logic             accept, step, last;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;

  assign a_sl = row0_q[idx_q*CHUNK +: CHUNK];
  assign b_sl = row1_q[idx_q*CHUNK +: CHUNK];

  ripple_slice_adder #(.W(CHUNK)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (s_sl),
    .cout (c_sl)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && !rst) begin
          accept  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (idx_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      row0_q   <= '0;
      row1_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        row0_q   <= bus.in_row0;
        row1_q   <= bus.in_row1;
        carry_q  <= 1'b0;
        idx_q    <= '0;
        result_q <= '0;
        ovf_q    <= 1'b0;
      end else if (step) begin
        result_q[idx_q*CHUNK +: CHUNK] <= s_sl;
        carry_q <= c_sl;
        idx_q   <= idx_q + 1'b1;
        // The carry out of the top slice is the overflow flag.
        if (last) ovf_q <= c_sl;
      end
    end
  end

  // in_ready is gated by rst so no accept can be signalled during reset.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_prod  = result_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule
